seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 25000, clk cycles each digit is driven (1 kHz per digit at 100 MHz).
REQ-002 Parameter BLANK_CYC, default 250, clk cycles with all anodes off between digits (anti-ghosting).
REQ-003 clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-high despite the name.
REQ-005 ones, tens, hundreds, thousands  input  4 each  BCD digits from the upstream digit counter.
REQ-006 blank_lz  input  1  1 = suppress leading zeros.
REQ-007 an  output  4  anode enables, active-low; an[0] = ones, an[3] = thousands.
REQ-008 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 Inputs (16 digit bits plus blank_lz) SHALL be registered in an input stage every clk cycle.
REQ-010 FSM states: GAP (an=1111, seg=1111111) and DRIVE (one digit lit).
REQ-011 GAP SHALL last exactly BLANK_CYC cycles, then go to DRIVE with idx = idx+1 mod 4.
REQ-012 DRIVE SHALL last exactly REFRESH_DIV cycles, then go to GAP with idx unchanged.
REQ-013 On GAP->DRIVE with new idx = 0, the input-stage contents SHALL be copied into a frame snapshot; all four digits of a frame display that snapshot (no tearing).
REQ-014 Digit order SHALL be 0,1,2,3,0,...; full frame = 4*(REFRESH_DIV+BLANK_CYC) cycles.
REQ-015 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 Snapshot digit value 10-15 SHALL display a dash, seg=0111111.
REQ-017 With snapshot blank_lz=1: thousands blanked if 0; hundreds if thousands and hundreds are 0; tens if thousands, hundreds and tens are 0; ones never blanked.
REQ-018 A blanked digit SHALL keep its anode off (an=1111) and seg=1111111 for its whole DRIVE slot; slot timing is unchanged.
REQ-019 an and seg SHALL both be registered and change on the same clk edge.
REQ-020 The phase counter SHALL be $clog2(REFRESH_DIV) bits wide and return to 0 at each state change.
REQ-021 Required: BLANK_CYC >= 1 and REFRESH_DIV >= 2; other values unsupported.

Reset
REQ-022 While rst_n=1: state=GAP, idx=3, counter=0, snapshot=0, input stage=0, an=1111, seg=1111111.
REQ-023 Reset asserted mid-operation SHALL force REQ-022 values on the next edge.
REQ-024 After release, the first DRIVE (idx 0, fresh snapshot) SHALL begin BLANK_CYC cycles later.

Structure
REQ-025 Segment code constants (blank, dash, digit patterns) and the default REFRESH_DIV/BLANK_CYC SHALL be in the shared display package.
REQ-026 Combinational decoder SHALL be one sub-module, bcd_to_7seg (4-bit in, 7-bit active-low out, dash for 10-15).

Verification (REFRESH_DIV=4, BLANK_CYC=2)
REQ-027 Hold rst_n=1 three cycles, release -> an=1111, seg=1111111 for 2 cycles, then an=1110 for 4 cycles.
REQ-028 thousands..ones=1,2,3,4, blank_lz=0 -> an/seg: 1110/0011001, 1101/0110000, 1011/0100100, 0111/1111001; each 4 cycles with 2-cycle an=1111 gaps.
REQ-029 digits 0,0,0,7, blank_lz=1 -> ones slot 1110/1111000, other slots an=1111; digits 0,0,0,0 -> ones slot 1110/1000000.
REQ-030 tens=4'hC -> tens slot an=1101, seg=0111111.
REQ-031 Change ones 4->5 during the tens DRIVE slot -> ones shows 4 until the next frame, then 5.
REQ-032 Assert rst_n during the hundreds DRIVE slot -> an=1111 on the next edge; first digit after release is ones.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// Shared display constants and types for the multiplexed 4-digit 7-segment scanner.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package seg7_scan_pkg;

  localparam int DEF_REFRESH_DIV = 25000;
  localparam int DEF_BLANK_CYC   = 250;

  localparam logic [3:0] AN_OFF    = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic {ST_GAP, ST_DRIVE} state_t;

  // d[0] = ones ... d[3] = thousands
  typedef struct packed {
    logic            lz;
    logic [3:0][3:0] d;
  } frame_t;

  // Leading-zero suppression: a digit blanks only if it and every higher digit are zero.
  function automatic logic lz_blank(input frame_t f, input logic [1:0] idx);
    logic b;
    case (idx)
      2'd3:    b = f.lz && (f.d[3] == 4'd0);
      2'd2:    b = f.lz && (f.d[3] == 4'd0) && (f.d[2] == 4'd0);
      2'd1:    b = f.lz && (f.d[3] == 4'd0) && (f.d[2] == 4'd0) && (f.d[1] == 4'd0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seg7_scan_bcd.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
  import seg7_scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed 7-segment scanner: GAP/DRIVE slots per digit, per-frame input
// snapshot so all four digits of a frame come from one coherent sample.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BLANK_CYC   = DEF_BLANK_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  DRV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(BLANK_CYC - 1);

  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  frame_t        r_in;
  frame_t        r_snap;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;

  logic [1:0] w_nidx;
  frame_t     w_frame;
  logic [3:0] w_dig;
  logic       w_blank;
  logic [6:0] w_dec_seg;
  logic [3:0] w_an_on;

  // The digit about to be driven; idx 0 reads the snapshot being loaded on this edge.
  assign w_nidx  = r_idx + 2'd1;
  assign w_frame = (w_nidx == 2'd0) ? r_in : r_snap;
  assign w_dig   = w_frame.d[w_nidx];
  assign w_blank = lz_blank(w_frame, w_nidx);
  assign w_an_on = ~(4'b0001 << w_nidx);

  bcd_to_7seg u_dec (
    .i_bcd (w_dig),
    .o_seg (w_dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= ST_GAP;
      r_idx   <= 2'd3;
      r_cnt   <= '0;
      r_in    <= '0;
      r_snap  <= '0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_BLANK;
    end else begin
      r_in <= {blank_lz, thousands, hundreds, tens, ones};
      case (r_state)
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_DRIVE;
            r_idx   <= w_nidx;
            r_cnt   <= '0;
            if (w_nidx == 2'd0) r_snap <= r_in;
            if (w_blank) begin
              r_an  <= AN_OFF;
              r_seg <= SEG_BLANK;
            end else begin
              r_an  <= w_an_on;
              r_seg <= w_dec_seg;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (r_cnt == DRV_LAST) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with REFRESH_DIV=4, BLANK_CYC=2: per-cycle an/seg scoreboard fed
// from a frame table, plus mid-frame input change and mid-slot reset sequences.
module tb_seg7_scan;

  localparam logic [3:0] A3 = 4'b0111;
  localparam logic [3:0] A2 = 4'b1011;
  localparam logic [3:0] A1 = 4'b1101;
  localparam logic [3:0] A0 = 4'b1110;
  localparam logic [3:0] AX = 4'b1111;
  localparam logic [6:0] BL = 7'b1111111;
  localparam int         NV = 8;

  typedef struct packed {
    logic [3:0]      th, hu, te, on;
    logic            lz;
    logic [3:0][3:0] ae;  // expected anodes per slot, [0] = ones
    logic [3:0][6:0] se;  // expected segments per slot
  } vec_t;

  typedef struct packed {
    int         id;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ones, tens, hundreds, thousands;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;

  vec_t vecs [NV];
  exp_t q[$];
  exp_t e;
  int   seq_id = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic run = 1'b0;
  logic fin_chk = 1'b0;
  logic fin_done = 1'b0;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(4), .BLANK_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .blank_lz  (blank_lz),
    .an        (an),
    .seg       (seg)
  );

  // Every cycle after the edge: pop one expected an/seg pair and compare.
  always @(posedge clk) begin
    #1;
    if (run) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL scan_underflow: scoreboard empty, an=%b seg=%b", an, seg);
      end else begin
        e = q.pop_front();
        if (an !== e.an || seg !== e.seg) begin
          n_err++;
          $display("FAIL scan#%0d: got an=%b seg=%b, want an=%b seg=%b",
                   e.id, an, seg, e.an, e.seg);
        end
      end
    end
    if (fin_chk && !fin_done) begin
      fin_done = 1'b1;
      n_vec++;
      if (q.size() != 0) begin
        n_err++;
        $display("FAIL scan_drain: %0d expected entries left, want 0", q.size());
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [6:0] s);
    q.push_back('{seq_id, a, s});
    seq_id++;
  endtask

  task automatic push_gap(input int n);
    for (int k = 0; k < n; k++) push(AX, BL);
  endtask

  // One full frame: each digit DRIVE slot (4 cycles) followed by its GAP (2 cycles).
  task automatic push_frame(input logic [3:0][3:0] ae, input logic [3:0][6:0] se);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) push(ae[s], se[s]);
      push_gap(2);
    end
  endtask

  task automatic apply(input vec_t v);
    thousands = v.th;
    hundreds  = v.hu;
    tens      = v.te;
    ones      = v.on;
    blank_lz  = v.lz;
  endtask

  initial begin
    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, {A3, A2, A1, A0},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{4'd0, 4'd0, 4'd0, 4'd7, 1'b1, {AX, AX, AX, A0},
                {BL, BL, BL, 7'b1111000}};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b1, {AX, AX, AX, A0},
                {BL, BL, BL, 7'b1000000}};
    vecs[3] = '{4'd0, 4'd0, 4'hC, 4'd0, 1'b0, {A3, A2, A1, A0},
                {7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000}};
    vecs[4] = '{4'd0, 4'd5, 4'd0, 4'd8, 1'b1, {AX, A2, A1, A0},
                {BL, 7'b0010010, 7'b1000000, 7'b0000000}};
    vecs[5] = '{4'd0, 4'd0, 4'd9, 4'd6, 1'b1, {AX, AX, A1, A0},
                {BL, BL, 7'b0010000, 7'b0000010}};
    vecs[6] = '{4'd8, 4'hF, 4'd0, 4'hA, 1'b1, {A3, A2, A1, A0},
                {7'b0000000, 7'b0111111, 7'b1000000, 7'b0111111}};
    vecs[7] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, {A3, A2, A1, A0},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};

    // Three reset cycles, then one gap cycle, then frame 0.
    rst_n = 1'b1;
    apply(vecs[0]);
    push_gap(4);
    push_frame(vecs[0].ae, vecs[0].se);
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Now just past the first DRIVE edge of frame 0; inputs set here show next frame.
    for (int f = 1; f < NV; f++) begin
      apply(vecs[f]);
      push_frame(vecs[f].ae, vecs[f].se);
      repeat (24) @(negedge clk);
    end

    // Frame T shows 1,2,3,4; during its tens slot change ones 4->5 and thousands 1->9.
    apply(vecs[0]);
    push_frame(vecs[0].ae, vecs[0].se);
    repeat (24) @(negedge clk);
    repeat (6) @(negedge clk);
    ones      = 4'd5;
    thousands = 4'd9;
    push_frame({A3, A2, A1, A0}, {7'b0010000, 7'b0100100, 7'b0110000, 7'b0010010});
    repeat (18) @(negedge clk);

    // Reset in the middle of the hundreds DRIVE slot of frame T+1.
    repeat (13) @(negedge clk);
    rst_n     = 1'b1;
    thousands = 4'd0;
    hundreds  = 4'd0;
    tens      = 4'd4;
    ones      = 4'd2;
    blank_lz  = 1'b1;
    q.delete();
    push_gap(3);
    push_frame({AX, AX, A1, A0}, {BL, BL, 7'b0011001, 7'b0100100});
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (25) @(negedge clk);

    run     = 1'b0;
    fin_chk = 1'b1;
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
